// File: rtl/change_dispenser.sv
// Greedy change payout: issues 50/20/10/5/1 coins over a valid/ack handshake until the owed amount is paid.
// Optional CHANGE_INVENTORY_EN adds per-denomination stock counters, refill and shortfall reporting.
module change_dispenser #(
  parameter int         COIN_GAP   = 4,
  parameter logic [7:0] INIT_STOCK = 8'd15
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] change_amount,
  input  logic       coin_ack,
  input  logic       refill,
  output logic       busy,
  output logic       coin_valid,
  output logic [2:0] coin_denom,
  output logic [7:0] remaining,
  output logic [7:0] coin_count,
  output logic       done,
  output logic       shortfall
);
  localparam int NUM_DENOM = 5;
  localparam int GW        = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_GAP, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [NUM_DENOM-1:0] avail;
  logic [2:0]           pick;
  logic [GW-1:0]        gap_cnt;
  logic                 busy_nxt, valid_nxt, done_nxt;
  logic                 ack_take;

  function automatic logic [7:0] denom_value(input logic [2:0] d);
    case (d)
      3'd1:    return 8'd1;
      3'd2:    return 8'd5;
      3'd3:    return 8'd10;
      3'd4:    return 8'd20;
      3'd5:    return 8'd50;
      default: return 8'd0;
    endcase
  endfunction

  assign ack_take = (state == S_ISSUE) && coin_ack;

  // Ascending scan so the largest fitting, available denomination wins.
  always_comb begin
    pick = 3'd0;
    for (int i = 1; i <= NUM_DENOM; i++)
      if (avail[i-1] && (denom_value(3'(i)) <= remaining) && (remaining != 8'd0))
        pick = 3'(i);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SELECT;
      S_SELECT: state_nxt = (pick == 3'd0) ? S_DONE : S_ISSUE;
      S_ISSUE:  if (coin_ack) state_nxt = (COIN_GAP == 0) ? S_SELECT : S_GAP;
      S_GAP:    if (gap_cnt == '0) state_nxt = S_SELECT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so coin_ack never reaches coin_valid combinationally.
  always_comb begin
    busy_nxt  = (state_nxt != S_IDLE);
    valid_nxt = (state_nxt == S_ISSUE);
    done_nxt  = (state == S_DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      busy       <= 1'b0;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      coin_denom <= 3'd0;
      remaining  <= 8'd0;
      coin_count <= 8'd0;
      gap_cnt    <= '0;
    end else begin
      busy       <= busy_nxt;
      coin_valid <= valid_nxt;
      done       <= done_nxt;
      case (state)
        S_IDLE:
          if (start) begin
            remaining  <= change_amount;
            coin_count <= 8'd0;
          end
        S_SELECT:
          if (pick != 3'd0) coin_denom <= pick;
        S_ISSUE:
          if (coin_ack) begin
            remaining  <= remaining - denom_value(coin_denom);
            coin_count <= (coin_count == 8'hFF) ? coin_count : coin_count + 8'd1;
            coin_denom <= 3'd0;
            gap_cnt    <= GW'(COIN_GAP - 1);
          end
        S_GAP:
          gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end

`ifdef CHANGE_INVENTORY_EN
  logic short_q;

  for (genvar g = 0; g < NUM_DENOM; g++) begin : g_stock
    logic [7:0] stock;
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n)                                stock <= INIT_STOCK;
      else if (state == S_IDLE && !start && refill)  stock <= INIT_STOCK;
      else if (ack_take && coin_denom == 3'(g + 1))  stock <= stock - 8'd1;
    assign avail[g] = (stock != 8'd0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n)                                           short_q <= 1'b0;
    else if (state == S_IDLE && start)                        short_q <= 1'b0;
    else if (state == S_SELECT && remaining != 8'd0 && pick == 3'd0) short_q <= 1'b1;

  assign shortfall = short_q;
`else
  logic unused_cfg;
  assign avail      = '1;
  assign shortfall  = 1'b0;
  assign unused_cfg = ^{refill, INIT_STOCK, ack_take};
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench: two dispensers (COIN_GAP 0 and 4) against a greedy payout model.
module tb_change_dispenser;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [1:0] start_v = '0, ack_v = '0;
  logic [7:0] amt = 8'd0;
  logic       refill = 1'b0;
  logic       busy_w[2], valid_w[2], done_w[2], short_w[2];
  logic [2:0] denom_w[2];
  logic [7:0] rem_w[2], cnt_w[2];

  int n_chk = 0, n_pass = 0;
  int vals[5] = '{1, 5, 10, 20, 50};
  int mstock[2][5];
  logic [2:0] exp_q[$];
  int exp_rem;
  bit exp_short;

  always #5 sys_clk = ~sys_clk;

  change_dispenser #(.COIN_GAP(0)) dut_g0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[0]), .change_amount(amt),
    .coin_ack(ack_v[0]), .refill(refill), .busy(busy_w[0]), .coin_valid(valid_w[0]),
    .coin_denom(denom_w[0]), .remaining(rem_w[0]), .coin_count(cnt_w[0]), .done(done_w[0]),
    .shortfall(short_w[0]));

  change_dispenser #(.COIN_GAP(4)) dut_g4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[1]), .change_amount(amt),
    .coin_ack(ack_v[1]), .refill(refill), .busy(busy_w[1]), .coin_valid(valid_w[1]),
    .coin_denom(denom_w[1]), .remaining(rem_w[1]), .coin_count(cnt_w[1]), .done(done_w[1]),
    .shortfall(short_w[1]));

  function automatic void reload_stock();
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 5; i++) mstock[g][i] = 15;
  endfunction

  function automatic bit has_stock(input int g, input int i);
`ifdef CHANGE_INVENTORY_EN
    return mstock[g][i] > 0;
`else
    return 1'b1;
`endif
  endfunction

  // Greedy payout: repeatedly take the biggest coin that fits and is in stock.
  function automatic void build_expect(input int g, input int a);
    int  r = a;
    bit  found;
    exp_q.delete();
    do begin
      found = 1'b0;
      for (int i = 4; i >= 0 && !found; i--)
        if (r > 0 && vals[i] <= r && has_stock(g, i)) begin
          exp_q.push_back(3'(i + 1));
          r -= vals[i];
          mstock[g][i]--;
          found = 1'b1;
        end
    end while (found);
    exp_rem   = r;
    exp_short = (r != 0);
  endfunction

  task automatic run_txn(input int g, input int a, input int hold, input bit poke);
    int gap = (g == 1) ? 4 : 0;
    int cyc, h, lat, rem_run;
    bit saw_valid;
    build_expect(g, a);
    rem_run = a;
    @(negedge sys_clk); amt = 8'(a); start_v[g] = 1'b1;
    @(negedge sys_clk); start_v[g] = 1'b0;
    n_chk++; if (busy_w[g] !== 1'b1) $display("FAIL busy_after_start g%0d: got %b want 1", g, busy_w[g]); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc = 0;
      while (valid_w[g] !== 1'b1 && cyc < 64) begin @(negedge sys_clk); cyc++; end
      lat = (i == 0) ? 1 : gap + 1;
      n_chk++; if (cyc !== lat) $display("FAIL valid_latency g%0d coin%0d: got %0d want %0d", g, i, cyc, lat); else n_pass++;
      n_chk++; if (denom_w[g] !== exp_q[i]) $display("FAIL denom g%0d amt%0d coin%0d: got %0d want %0d", g, a, i, denom_w[g], exp_q[i]); else n_pass++;
      h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      for (int j = 0; j < h; j++) begin
        if (poke && i == 0 && j == 0) begin amt = 8'd99; start_v[g] = 1'b1; end
        @(negedge sys_clk);
        start_v[g] = 1'b0; amt = 8'(a);
        n_chk++; if ({valid_w[g], denom_w[g]} !== {1'b1, exp_q[i]})
          $display("FAIL hold_stable g%0d cyc%0d: got v%b d%0d want v1 d%0d", g, j, valid_w[g], denom_w[g], exp_q[i]);
        else n_pass++;
      end
      ack_v[g] = 1'b1;
      @(negedge sys_clk); ack_v[g] = 1'b0;
      rem_run -= vals[exp_q[i] - 1];
      n_chk++; if (valid_w[g] !== 1'b0) $display("FAIL valid_drop g%0d: got %b want 0", g, valid_w[g]); else n_pass++;
      n_chk++; if (rem_w[g] !== 8'(rem_run)) $display("FAIL remaining g%0d coin%0d: got %0d want %0d", g, i, rem_w[g], rem_run); else n_pass++;
      n_chk++; if (cnt_w[g] !== 8'(i + 1)) $display("FAIL count g%0d coin%0d: got %0d want %0d", g, i, cnt_w[g], i + 1); else n_pass++;
    end
    cyc = 0; saw_valid = 1'b0;
    while (done_w[g] !== 1'b1 && cyc < 64) begin
      @(negedge sys_clk); cyc++;
      if (valid_w[g] === 1'b1) saw_valid = 1'b1;
    end
    lat = (exp_q.size() == 0) ? 2 : gap + 2;
    n_chk++; if (cyc !== lat) $display("FAIL done_latency g%0d amt%0d: got %0d want %0d", g, a, cyc, lat); else n_pass++;
    n_chk++; if (saw_valid !== 1'b0) $display("FAIL extra_coin g%0d amt%0d: got valid %b want 0", g, a, saw_valid); else n_pass++;
    n_chk++; if ({busy_w[g], rem_w[g], cnt_w[g], short_w[g]} !== {1'b0, 8'(exp_rem), 8'(exp_q.size()), exp_short})
      $display("FAIL final g%0d amt%0d: got b%b r%0d c%0d s%b want b0 r%0d c%0d s%b", g, a,
               busy_w[g], rem_w[g], cnt_w[g], short_w[g], exp_rem, exp_q.size(), exp_short);
    else n_pass++;
    @(negedge sys_clk);
    n_chk++; if ({done_w[g], busy_w[g]} !== 2'b00) $display("FAIL done_pulse g%0d: got d%b b%b want 00", g, done_w[g], busy_w[g]); else n_pass++;
  endtask

  task automatic test_reset();
    #2 sys_rst_n = 1'b0;
    reload_stock();
    repeat (2) @(negedge sys_clk);
    for (int g = 0; g < 2; g++) begin
      n_chk++; if ({busy_w[g], valid_w[g], denom_w[g], rem_w[g], cnt_w[g], done_w[g], short_w[g]} !== '0)
        $display("FAIL reset_state g%0d: got b%b v%b d%0d r%0d c%0d dn%b s%b want all 0", g,
                 busy_w[g], valid_w[g], denom_w[g], rem_w[g], cnt_w[g], done_w[g], short_w[g]);
      else n_pass++;
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_greedy();
    run_txn(0, 87, 0, 1'b0);
    n_chk++; if (cnt_w[0] !== 8'd6) $display("FAIL greedy87_count: got %0d want 6", cnt_w[0]); else n_pass++;
  endtask

  task automatic test_zero();
    run_txn(0, 0, 0, 1'b0);
    run_txn(1, 0, 0, 1'b0);
  endtask

  task automatic test_stall_and_gap();
    run_txn(0, 20, 10, 1'b0);
    run_txn(1, 25, -1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_txn(0, 30, 2, 1'b1);
    n_chk++; if (cnt_w[0] !== 8'd2) $display("FAIL busy_start_count: got %0d want 2", cnt_w[0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit saw_done = 1'b0;
    @(negedge sys_clk); amt = 8'd60; start_v[1] = 1'b1;
    @(negedge sys_clk); start_v[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cyc = 0;
      while (valid_w[1] !== 1'b1 && cyc < 64) begin @(negedge sys_clk); cyc++; end
      if (c == 0) begin ack_v[1] = 1'b1; @(negedge sys_clk); ack_v[1] = 1'b0; end
    end
    n_chk++; if (denom_w[1] !== 3'd3) $display("FAIL mid_second_coin: got %0d want 3", denom_w[1]); else n_pass++;
    #2 sys_rst_n = 1'b0;
    reload_stock();
    #1;
    n_chk++; if ({busy_w[1], valid_w[1], denom_w[1], rem_w[1], cnt_w[1], done_w[1], short_w[1]} !== '0)
      $display("FAIL async_reset: got b%b v%b d%0d r%0d c%0d dn%b want all 0",
               busy_w[1], valid_w[1], denom_w[1], rem_w[1], cnt_w[1], done_w[1]);
    else n_pass++;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (8) begin @(negedge sys_clk); if (done_w[1] === 1'b1 || busy_w[1] === 1'b1) saw_done = 1'b1; end
    n_chk++; if (saw_done !== 1'b0) $display("FAIL post_reset_idle: got activity %b want 0", saw_done); else n_pass++;
    run_txn(1, 60, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++)
      run_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), -1, 1'b0);
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic do_refill();
    @(negedge sys_clk); refill = 1'b1;
    @(negedge sys_clk); refill = 1'b0;
    reload_stock();
  endtask

  task automatic test_inventory();
    do_refill();
    repeat (3) run_txn(0, 250, 0, 1'b0);
    repeat (3) run_txn(0, 4, 0, 1'b0);
    run_txn(0, 1, 0, 1'b0);
    run_txn(0, 60, 0, 1'b0);
    n_chk++; if (cnt_w[0] !== 8'd3) $display("FAIL inv60_count: got %0d want 3", cnt_w[0]); else n_pass++;
    run_txn(0, 3, 0, 1'b0);
    n_chk++; if ({short_w[0], rem_w[0], cnt_w[0]} !== {1'b1, 8'd1, 8'd2})
      $display("FAIL inv_shortfall: got s%b r%0d c%0d want s1 r1 c2", short_w[0], rem_w[0], cnt_w[0]);
    else n_pass++;
    do_refill();
    run_txn(0, 3, 0, 1'b0);
    n_chk++; if ({short_w[0], rem_w[0], cnt_w[0]} !== {1'b0, 8'd0, 8'd3})
      $display("FAIL inv_refill: got s%b r%0d c%0d want s0 r0 c3", short_w[0], rem_w[0], cnt_w[0]);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_greedy();
    test_zero();
    test_stall_and_gap();
    test_start_while_busy();
    test_reset_mid();
    test_random();
`ifdef CHANGE_INVENTORY_EN
    test_inventory();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
